// File: rtl/pong_pkg.sv
// Shared state encodings, text-region masks and widths for the pong game controller.
package pong_pkg;

  localparam int unsigned TIMER_W = 8;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  // Region order is {score, pong, rule, over}
  localparam logic [3:0] SHOW_NEWGAME = 4'b1110;
  localparam logic [3:0] SHOW_PLAY    = 4'b1000;
  localparam logic [3:0] SHOW_OVER    = 4'b1001;

endpackage

// File: rtl/pong_game_ctrl_bcd_counter2.sv
// Two-digit BCD score counter that saturates at 99; clr wins over inc.
module bcd_counter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] dig1,
  output logic [3:0] dig0
);

  logic at_max_c;

  assign at_max_c = (dig1 == 4'd9) && (dig0 == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig1 <= 4'd0;
      dig0 <= 4'd0;
    end else if (clr) begin
      dig1 <= 4'd0;
      dig0 <= 4'd0;
    end else if (inc && !at_max_c) begin
      if (dig0 == 4'd9) begin
        dig0 <= 4'd0;
        dig1 <= dig1 + 4'd1;
      end else begin
        dig0 <= dig0 + 4'd1;
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: tracks score, balls and frame-timed pauses, and selects
// which text regions the overlay renderer draws.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned START_BALLS  = 3,
  parameter int unsigned DELAY_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] btn,
  input  logic       refresh_tick,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] one_digit,
  output logic [3:0] ten_digit,
  output logic [1:0] ball,
  output logic [3:0] text_show,
  output logic       graph_still,
  output logic [1:0] state
);

  state_t               state_q, state_d;
  logic [1:0]           btn_q;
  logic [TIMER_W-1:0]   timer_q;
  logic                 press_c;
  logic                 timer_done_c;
  logic                 play_miss_c;
  logic                 game_reload_c;
  logic                 score_inc_c;

  // btn_q resets high so a button held through reset is not seen as a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= 2'b11;
    else        btn_q <= btn;
  end

  assign press_c       = |(btn & ~btn_q);
  assign timer_done_c  = (timer_q == '0);
  assign play_miss_c   = (state_q == ST_PLAY) && miss;
  assign score_inc_c   = (state_q == ST_PLAY) && hit;
  assign game_reload_c = (state_q == ST_OVER) && timer_done_c;

  // Frame timer: load on miss beats a same-cycle tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             timer_q <= '0;
    else if (play_miss_c)                   timer_q <= TIMER_W'(DELAY_FRAMES);
    else if (refresh_tick && !timer_done_c) timer_q <= timer_q - TIMER_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             ball <= 2'(START_BALLS);
    else if (game_reload_c) ball <= 2'(START_BALLS);
    else if (play_miss_c)   ball <= (ball > 2'd1) ? ball - 2'd1 : 2'd0;
  end

  bcd_counter2 u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (game_reload_c),
    .inc   (score_inc_c),
    .dig1  (ten_digit),
    .dig0  (one_digit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_NEWGAME;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_NEWGAME: if (press_c) state_d = ST_PLAY;
      ST_PLAY:    if (miss)    state_d = (ball > 2'd1) ? ST_NEWBALL : ST_OVER;
      ST_NEWBALL: if (press_c && timer_done_c) state_d = ST_PLAY;
      ST_OVER:    if (timer_done_c) state_d = ST_NEWGAME;
      default:    state_d = ST_NEWGAME;
    endcase
  end

  always_comb begin
    text_show   = SHOW_NEWGAME;
    graph_still = 1'b1;
    unique case (state_q)
      ST_NEWGAME: text_show = SHOW_NEWGAME;
      ST_PLAY: begin
        text_show   = SHOW_PLAY;
        graph_still = 1'b0;
      end
      ST_NEWBALL: text_show = SHOW_PLAY;
      ST_OVER:    text_show = SHOW_OVER;
      default:    text_show = SHOW_NEWGAME;
    endcase
  end

  assign state = state_q;

endmodule
